// File: rtl/dual_port_ram_ctrl.sv
// True dual-port, single-clock RAM with per-byte write enables, a 1- or
// 2-cycle read pipeline, a selectable read-during-write view, same-address
// collision reporting and a hardware clear sequencer.
module dual_port_ram_ctrl #(
   parameter int    DATA_WIDTH     = 16,
   parameter int    ADDR_WIDTH     = 10,
   parameter int    BYTE_WIDTH     = 8,
   parameter int    READ_LATENCY   = 1,
   parameter int    WRITE_FIRST    = 1,
   parameter string INIT_FILE      = "init.txt",
   parameter int    CLEAR_ON_RESET = 0
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                clear,
   output logic                                busy,
   input  logic                                en_a,
   input  logic                                we_a,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]    be_a,
   input  logic [ADDR_WIDTH-1:0]               addr_a,
   input  logic [DATA_WIDTH-1:0]               data_a,
   output logic [DATA_WIDTH-1:0]               q_a,
   output logic                                valid_a,
   input  logic                                en_b,
   input  logic                                we_b,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]    be_b,
   input  logic [ADDR_WIDTH-1:0]               addr_b,
   input  logic [DATA_WIDTH-1:0]               data_b,
   output logic [DATA_WIDTH-1:0]               q_b,
   output logic                                valid_b,
   output logic                                collision
);

   localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_PAIR = ADDR_WIDTH'(DEPTH - 2);

   // Reject configurations the datapath cannot represent.
   generate
      if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_err_bw
         $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
      end
      if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_err_rl
         $error("READ_LATENCY must be 1 or 2");
      end
      if (ADDR_WIDTH < 2) begin : g_err_aw
         $error("ADDR_WIDTH must be at least 2");
      end
   endgenerate

   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   state_t                r_state, w_state_nx;
   logic [ADDR_WIDTH-1:0] r_ptr, w_ptr_nx;
   logic                  r_init_pend;

   logic                  w_busy, w_acc_a, w_acc_b, w_wr_a, w_wr_b, w_same, w_col;
   logic [DATA_WIDTH-1:0] w_old_a, w_old_b, w_new_a, w_new_b;

   assign w_busy  = (r_state == S_CLEAR);
   assign busy    = w_busy;
   assign w_acc_a = en_a & ~w_busy;
   assign w_acc_b = en_b & ~w_busy;
   assign w_wr_a  = w_acc_a & we_a;
   assign w_wr_b  = w_acc_b & we_b;
   assign w_same  = (addr_a == addr_b);
   assign w_col   = w_acc_a & w_acc_b & w_same & (we_a | we_b);
   assign w_old_a = r_mem[addr_a];
   assign w_old_b = r_mem[addr_b];

   // Final word at each port's address after this cycle's writes; B lanes are
   // applied first so A wins any lane both ports enable on a shared address.
   always_comb begin
      w_new_a = w_old_a;
      w_new_b = w_old_b;
      for (int l = 0; l < NB; l++) begin
         if (w_wr_b && be_b[l]) begin
            w_new_b[l*BYTE_WIDTH +: BYTE_WIDTH] = data_b[l*BYTE_WIDTH +: BYTE_WIDTH];
            if (w_same) w_new_a[l*BYTE_WIDTH +: BYTE_WIDTH] = data_b[l*BYTE_WIDTH +: BYTE_WIDTH];
         end
         if (w_wr_a && be_a[l]) begin
            w_new_a[l*BYTE_WIDTH +: BYTE_WIDTH] = data_a[l*BYTE_WIDTH +: BYTE_WIDTH];
            if (w_same) w_new_b[l*BYTE_WIDTH +: BYTE_WIDTH] = data_a[l*BYTE_WIDTH +: BYTE_WIDTH];
         end
      end
   end

   // Array writes: clear pairs while busy, otherwise merged port words
   // (on a shared address both ports carry the same final word).
   always_ff @(posedge clk) begin
      if (w_busy) begin
         r_mem[r_ptr]         <= '0;
         r_mem[r_ptr | 'd1]   <= '0;
      end else begin
         if (w_wr_b) r_mem[addr_b] <= w_new_b;
         if (w_wr_a) r_mem[addr_a] <= w_new_a;
      end
   end

   // Clear sequencer state; reset aborts a running clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_ptr       <= '0;
         r_init_pend <= (CLEAR_ON_RESET != 0);
      end else begin
         r_state     <= w_state_nx;
         r_ptr       <= w_ptr_nx;
         r_init_pend <= 1'b0;
      end
   end

   // Next state: two words per cycle, leave after the last pair.
   always_comb begin
      w_state_nx = r_state;
      w_ptr_nx   = r_ptr;
      case (r_state)
         S_IDLE: begin
            if (clear || r_init_pend) begin
               w_state_nx = S_CLEAR;
               w_ptr_nx   = '0;
            end
         end
         S_CLEAR: begin
            w_ptr_nx = r_ptr + ADDR_WIDTH'(2);
            if (r_ptr == LAST_PAIR) begin
               w_state_nx = S_IDLE;
               w_ptr_nx   = '0;
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   logic                  r_v1_a, r_v1_b, r_c1;
   logic [DATA_WIDTH-1:0] r_d1_a, r_d1_b;

   // First response stage; data only moves on an accepted access so q holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1_a <= 1'b0;
         r_v1_b <= 1'b0;
         r_c1   <= 1'b0;
         r_d1_a <= '0;
         r_d1_b <= '0;
      end else begin
         r_v1_a <= w_acc_a;
         r_v1_b <= w_acc_b;
         r_c1   <= w_col;
         if (w_acc_a) r_d1_a <= (WRITE_FIRST != 0) ? w_new_a : w_old_a;
         if (w_acc_b) r_d1_b <= (WRITE_FIRST != 0) ? w_new_b : w_old_b;
      end
   end

   generate
      if (READ_LATENCY == 2) begin : g_rl2
         logic                  r_v2_a, r_v2_b, r_c2;
         logic [DATA_WIDTH-1:0] r_d2_a, r_d2_b;

         // Extra output stage; same throughput, one more cycle of latency.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_v2_a <= 1'b0;
               r_v2_b <= 1'b0;
               r_c2   <= 1'b0;
               r_d2_a <= '0;
               r_d2_b <= '0;
            end else begin
               r_v2_a <= r_v1_a;
               r_v2_b <= r_v1_b;
               r_c2   <= r_c1;
               if (r_v1_a) r_d2_a <= r_d1_a;
               if (r_v1_b) r_d2_b <= r_d1_b;
            end
         end

         assign q_a       = r_d2_a;
         assign q_b       = r_d2_b;
         assign valid_a   = r_v2_a;
         assign valid_b   = r_v2_b;
         assign collision = r_c2;
      end else begin : g_rl1
         assign q_a       = r_d1_a;
         assign q_b       = r_d1_b;
         assign valid_a   = r_v1_a;
         assign valid_b   = r_v1_b;
         assign collision = r_c1;
      end
   endgenerate

endmodule

// File: tb/tb_dual_port_ram_ctrl.sv
// Two instances share stimulus: u_d1 (latency 1, write-first) and
// u_d2 (latency 2, read-first, clear on reset). Expected words come from a
// hand-computed table and are queued per port, then popped when due.
module tb_dual_port_ram_ctrl;

   logic        clk, rst_n, clear;
   logic        en_a, we_a, en_b, we_b;
   logic [1:0]  be_a, be_b;
   logic [3:0]  addr_a, addr_b;
   logic [15:0] data_a, data_b;

   logic [15:0] q_a1, q_b1, q_a2, q_b2;
   logic        v_a1, v_b1, v_a2, v_b2, col1, col2, busy1, busy2;

   dual_port_ram_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .BYTE_WIDTH(8), .READ_LATENCY(1),
      .WRITE_FIRST(1), .INIT_FILE(""), .CLEAR_ON_RESET(0)) u_d1 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy1),
      .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .data_a(data_a),
      .q_a(q_a1), .valid_a(v_a1),
      .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .data_b(data_b),
      .q_b(q_b1), .valid_b(v_b1), .collision(col1));

   dual_port_ram_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .BYTE_WIDTH(8), .READ_LATENCY(2),
      .WRITE_FIRST(0), .INIT_FILE(""), .CLEAR_ON_RESET(1)) u_d2 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy2),
      .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .data_a(data_a),
      .q_a(q_a2), .valid_a(v_a2),
      .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .data_b(data_b),
      .q_b(q_b2), .valid_b(v_b2), .collision(col2));

   typedef struct {
      logic ea; logic wa; logic [1:0] bea; logic [3:0] aa; logic [15:0] da;
      logic eb; logic wb; logic [1:0] beb; logic [3:0] ab; logic [15:0] db;
      logic [15:0] qa1; logic [15:0] qa0; logic [15:0] qb1; logic [15:0] qb0;
      logic col;
   } vec_t;

   typedef struct { int due; logic [15:0] q; logic col; } sb_t;

   sb_t qa1[$], qb1[$], qa2[$], qb2[$];
   int  n_pass = 0, n_tot = 0, ncyc = 0;
   logic mon_en = 1'b0, chk2 = 1'b1;
   vec_t tbl [14];

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) ncyc <= ncyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
   endtask

   // Response monitor: a port must be valid exactly when its queue head is due.
   always @(negedge clk) if (mon_en) begin
      if (qa1.size() > 0 && qa1[0].due == ncyc) begin
         check("a1_valid", 32'(v_a1), 1); check("a1_q", 32'(q_a1), 32'(qa1[0].q));
         check("a1_col", 32'(col1), 32'(qa1[0].col)); void'(qa1.pop_front());
      end else if (v_a1) check("a1_extra_valid", 32'(v_a1), 0);
      if (qb1.size() > 0 && qb1[0].due == ncyc) begin
         check("b1_valid", 32'(v_b1), 1); check("b1_q", 32'(q_b1), 32'(qb1[0].q));
         check("b1_col", 32'(col1), 32'(qb1[0].col)); void'(qb1.pop_front());
      end else if (v_b1) check("b1_extra_valid", 32'(v_b1), 0);
      if (chk2) begin
         if (qa2.size() > 0 && qa2[0].due == ncyc) begin
            check("a2_valid", 32'(v_a2), 1); check("a2_q", 32'(q_a2), 32'(qa2[0].q));
            check("a2_col", 32'(col2), 32'(qa2[0].col)); void'(qa2.pop_front());
         end else if (v_a2) check("a2_extra_valid", 32'(v_a2), 0);
         if (qb2.size() > 0 && qb2[0].due == ncyc) begin
            check("b2_valid", 32'(v_b2), 1); check("b2_q", 32'(q_b2), 32'(qb2[0].q));
            check("b2_col", 32'(col2), 32'(qb2[0].col)); void'(qb2.pop_front());
         end else if (v_b2) check("b2_extra_valid", 32'(v_b2), 0);
      end
   end

   task automatic apply(input vec_t v);
      @(negedge clk);
      en_a = v.ea; we_a = v.wa; be_a = v.bea; addr_a = v.aa; data_a = v.da;
      en_b = v.eb; we_b = v.wb; be_b = v.beb; addr_b = v.ab; data_b = v.db;
      if (v.ea) begin
         qa1.push_back('{ncyc + 1, v.qa1, v.col});
         if (chk2) qa2.push_back('{ncyc + 2, v.qa0, v.col});
      end
      if (v.eb) begin
         qb1.push_back('{ncyc + 1, v.qb1, v.col});
         if (chk2) qb2.push_back('{ncyc + 2, v.qb0, v.col});
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         en_a = 1'b0; en_b = 1'b0; clear = 1'b0;
      end
   endtask

   // Count negedges with busy high, bounded so a stuck busy cannot hang.
   task automatic count_busy(output int c1, output int c2);
      c1 = 0; c2 = 0;
      for (int i = 0; i < 20; i++) begin
         if (busy1) c1++;
         if (busy2) c2++;
         if (!busy1 && !busy2) break;
         @(negedge clk);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int c1, c2;
      logic [15:0] e;
      vec_t v;
      //        ea wa bea    aa     da        eb wb beb    ab     db        qa1      qa0      qb1      qb0      col
      tbl[0]  = '{1, 1, 2'b11, 4'd5,  16'h1234, 1, 1, 2'b11, 4'd7,  16'hAABB, 16'h1234, 16'h0000, 16'hAABB, 16'h0000, 0};
      tbl[1]  = '{1, 1, 2'b11, 4'd9,  16'h00FF, 1, 0, 2'b00, 4'd5,  16'h0000, 16'h00FF, 16'h0000, 16'h1234, 16'h1234, 0};
      tbl[2]  = '{1, 0, 2'b00, 4'd5,  16'h0000, 0, 0, 2'b00, 4'd0,  16'h0000, 16'h1234, 16'h1234, 16'h0000, 16'h0000, 0};
      tbl[3]  = '{1, 1, 2'b01, 4'd7,  16'h1122, 0, 0, 2'b00, 4'd0,  16'h0000, 16'hAA22, 16'hAABB, 16'h0000, 16'h0000, 0};
      tbl[4]  = '{1, 1, 2'b10, 4'd3,  16'h1111, 1, 1, 2'b11, 4'd3,  16'h2222, 16'h1122, 16'h0000, 16'h1122, 16'h0000, 1};
      tbl[5]  = '{1, 0, 2'b00, 4'd3,  16'h0000, 1, 0, 2'b00, 4'd3,  16'h0000, 16'h1122, 16'h1122, 16'h1122, 16'h1122, 0};
      tbl[6]  = '{1, 0, 2'b00, 4'd9,  16'h0000, 1, 1, 2'b11, 4'd9,  16'hBEEF, 16'hBEEF, 16'h00FF, 16'hBEEF, 16'h00FF, 1};
      tbl[7]  = '{1, 1, 2'b00, 4'd2,  16'h5555, 1, 0, 2'b00, 4'd7,  16'h0000, 16'h0000, 16'h0000, 16'hAA22, 16'hAA22, 0};
      tbl[8]  = '{1, 0, 2'b00, 4'd2,  16'h0000, 1, 0, 2'b00, 4'd9,  16'h0000, 16'h0000, 16'h0000, 16'hBEEF, 16'hBEEF, 0};
      tbl[9]  = '{1, 0, 2'b00, 4'd7,  16'h0000, 1, 1, 2'b10, 4'd7,  16'hCD00, 16'hCD22, 16'hAA22, 16'hCD22, 16'hAA22, 1};
      tbl[10] = '{0, 0, 2'b00, 4'd0,  16'h0000, 1, 0, 2'b00, 4'd7,  16'h0000, 16'h0000, 16'h0000, 16'hCD22, 16'hCD22, 0};
      tbl[11] = '{1, 1, 2'b11, 4'd15, 16'h0102, 1, 1, 2'b11, 4'd0,  16'h0304, 16'h0102, 16'h0000, 16'h0304, 16'h0000, 0};
      tbl[12] = '{1, 0, 2'b00, 4'd0,  16'h0000, 1, 0, 2'b00, 4'd15, 16'h0000, 16'h0304, 16'h0304, 16'h0102, 16'h0102, 0};
      tbl[13] = '{1, 1, 2'b11, 4'd4,  16'hFFFF, 1, 0, 2'b00, 4'd4,  16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 1};

      rst_n = 1'b1; clear = 1'b0;
      en_a = 1'b0; we_a = 1'b0; be_a = '0; addr_a = '0; data_a = '0;
      en_b = 1'b0; we_b = 1'b0; be_b = '0; addr_b = '0; data_b = '0;

      // Reset state.
      #2 rst_n = 1'b0;
      #1;
      check("rst_busy1", 32'(busy1), 0);   check("rst_busy2", 32'(busy2), 0);
      check("rst_valid_a1", 32'(v_a1), 0); check("rst_q_a1", 32'(q_a1), 0);
      check("rst_q_b2", 32'(q_b2), 0);     check("rst_col1", 32'(col1), 0);

      // Release: u_d2 clears on its own, u_d1 by request on the same edge.
      repeat (2) @(negedge clk);
      rst_n = 1'b1; clear = 1'b1; mon_en = 1'b1;
      check("rel_busy2_before_edge", 32'(busy2), 0);
      @(negedge clk);
      clear = 1'b0;
      count_busy(c1, c2);
      check("init_clear_cycles1", 32'(c1), 8);
      check("init_clear_cycles2", 32'(c2), 8);

      for (int i = 0; i < 14; i++) apply(tbl[i]);
      idle(3);

      // Clear request with port A enabled throughout: no responses expected.
      @(negedge clk); clear = 1'b1;
      @(negedge clk); clear = 1'b0; en_a = 1'b1; we_a = 1'b0; addr_a = 4'd1;
      count_busy(c1, c2);
      en_a = 1'b0;
      check("clear_cycles1", 32'(c1), 8);
      check("clear_cycles2", 32'(c2), 8);
      for (int i = 0; i < 16; i++) begin
         v = '{1, 0, 2'b00, 4'(i), 16'h0, 1, 0, 2'b00, 4'(15 - i), 16'h0,
               16'h0, 16'h0, 16'h0, 16'h0, 0};
         apply(v);
      end
      idle(3);

      // Fill every word, then reset three pairs into a clear.
      for (int i = 0; i < 16; i++) begin
         e = 16'h1000 + 16'(i);
         v = '{1, 1, 2'b11, 4'(i), e, 0, 0, 2'b00, 4'd0, 16'h0, e, 16'h0, 16'h0, 16'h0, 0};
         apply(v);
      end
      idle(4);
      @(negedge clk); clear = 1'b1; chk2 = 1'b0;
      idle(4);
      rst_n = 1'b0;
      #1;
      check("midclr_busy1", 32'(busy1), 0);  check("midclr_valid_a1", 32'(v_a1), 0);
      check("midclr_q_a1", 32'(q_a1), 0);    check("midclr_q_b1", 32'(q_b1), 0);
      check("midclr_col1", 32'(col1), 0);    check("midclr_busy2", 32'(busy2), 0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      check("restart_busy2", 32'(busy2), 1);
      check("restart_busy1", 32'(busy1), 0);
      for (int i = 0; i < 16; i++) begin
         e = (i < 6) ? 16'h0 : 16'h1000 + 16'(i);
         v = '{1, 0, 2'b00, 4'(i), 16'h0, 0, 0, 2'b00, 4'd0, 16'h0, e, 16'h0, 16'h0, 16'h0, 0};
         apply(v);
      end
      idle(3);
      check("q_hold_a1", 32'(q_a1), 32'h100F);
      check("q_hold_valid_a1", 32'(v_a1), 0);
      check("drained_a1", 32'(qa1.size()), 0);
      check("drained_b1", 32'(qb1.size()), 0);
      check("drained_a2", 32'(qa2.size()), 0);
      check("drained_b2", 32'(qb2.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
